// File: rtl/alu_sequencer.sv
// Multi-cycle controller sequencing the 8-bit 6502 ALU: owns N/V/Z/C and performs two-pass ADD16.
// Optional decimal-mode ADC correction pass enabled by ALU_SEQUENCER_DECIMAL_EN.
module alu_sequencer (
    input  logic       clk,
    input  logic       resetn,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_op,
    input  logic [7:0] req_a,
    input  logic [7:0] req_b,
    input  logic [7:0] req_hi,
    input  logic       dec_mode,
    input  logic       flag_wr_en,
    input  logic [3:0] flag_wr_data,
    output logic [2:0] alu_control,
    output logic [7:0] alu_AI,
    output logic [7:0] alu_BI,
    output logic       alu_carry_in,
    input  logic [7:0] alu_Y,
    input  logic       alu_carry_out,
    output logic       rsp_valid,
    output logic [7:0] rsp_y,
    output logic [7:0] rsp_y_hi,
    output logic       rsp_page_cross,
    output logic       flag_n,
    output logic       flag_v,
    output logic       flag_z,
    output logic       flag_c
);

    localparam int unsigned DW   = 8;
    localparam int unsigned OPW  = 3;
    localparam int unsigned FLW  = 4;

    localparam logic [OPW-1:0] OP_ADC   = 3'b000;
    localparam logic [OPW-1:0] OP_SBC   = 3'b001;
    localparam logic [OPW-1:0] OP_AND   = 3'b010;
    localparam logic [OPW-1:0] OP_ORA   = 3'b011;
    localparam logic [OPW-1:0] OP_EOR   = 3'b100;
    localparam logic [OPW-1:0] OP_LSR   = 3'b101;
    localparam logic [OPW-1:0] OP_ADD16 = 3'b110;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SR  = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        EXEC_LO = 3'd1,
        EXEC_HI = 3'd2,
`ifdef ALU_SEQUENCER_DECIMAL_EN
        BCD_FIX = 3'd4,
`endif
        DONE    = 3'd3
    } state_t;

    state_t         state_q, state_d;
    logic [OPW-1:0] op_q, op_d;
    logic [DW-1:0]  a_q, a_d;
    logic [DW-1:0]  hi_q, hi_d;
    logic [DW-1:0]  y_lo_q, y_lo_d;
    logic           lo_carry_q, lo_carry_d;
    logic [2:0]     ctl_q, ctl_d;
    logic [DW-1:0]  ai_q, ai_d;
    logic [DW-1:0]  bi_q, bi_d;
    logic           cin_q, cin_d;
    logic           req_ready_q, req_ready_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]  rsp_y_q, rsp_y_d;
    logic [DW-1:0]  rsp_y_hi_q, rsp_y_hi_d;
    logic           rsp_pc_q, rsp_pc_d;
    logic [FLW-1:0] flags_q, flags_d;   // {N,V,Z,C}
    logic           to_done;
    logic           v_bin;

`ifdef ALU_SEQUENCER_DECIMAL_EN
    logic           dec_q, dec_d;
    logic           v_bin_q, v_bin_d;
    logic           hi_adj_q, hi_adj_d;
    logic [4:0]     lo_sum;
    logic [8:0]     bin_res;
    logic           lo_adj, hi_adj;
`else
    logic           dec_mode_unused;
    assign dec_mode_unused = dec_mode;
`endif

    // Next-state, operand capture, ALU drive and flag computation
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        hi_d        = hi_q;
        y_lo_d      = y_lo_q;
        lo_carry_d  = lo_carry_q;
        ctl_d       = ctl_q;
        ai_d        = ai_q;
        bi_d        = bi_q;
        cin_d       = cin_q;
        rsp_valid_d = 1'b0;
        rsp_y_d     = rsp_y_q;
        rsp_y_hi_d  = rsp_y_hi_q;
        rsp_pc_d    = rsp_pc_q;
        flags_d     = flags_q;
        to_done     = 1'b0;
        v_bin       = ~(ai_q[7] ^ bi_q[7]) & (ai_q[7] ^ alu_Y[7]);
`ifdef ALU_SEQUENCER_DECIMAL_EN
        dec_d       = dec_q;
        v_bin_d     = v_bin_q;
        hi_adj_d    = hi_adj_q;
        lo_sum      = 5'(ai_q[3:0]) + 5'(bi_q[3:0]) + 5'(cin_q);
        lo_adj      = lo_sum > 5'd9;
        bin_res     = {alu_carry_out, alu_Y};
        hi_adj      = (bin_res > 9'h099) || ((bin_res + (lo_adj ? 9'd6 : 9'd0)) > 9'h099);
`endif

        case (state_q)
            IDLE: begin
                ctl_d = ALU_ADD;
                ai_d  = '0;
                bi_d  = '0;
                cin_d = 1'b0;
                if (req_valid && req_ready_q) begin
                    op_d    = req_op;
                    a_d     = req_a;
                    hi_d    = req_hi;
                    state_d = EXEC_LO;
`ifdef ALU_SEQUENCER_DECIMAL_EN
                    dec_d   = dec_mode && (req_op == OP_ADC);
`endif
                    case (req_op)
                        OP_ADC:   begin ai_d = req_a; bi_d = req_b;  cin_d = flags_q[0]; end
                        OP_SBC:   begin ai_d = req_a; bi_d = ~req_b; cin_d = flags_q[0]; end
                        OP_AND:   begin ctl_d = ALU_AND; ai_d = req_a; bi_d = req_b; end
                        OP_ORA:   begin ctl_d = ALU_OR;  ai_d = req_a; bi_d = req_b; end
                        OP_EOR:   begin ctl_d = ALU_XOR; ai_d = req_a; bi_d = req_b; end
                        OP_LSR:   begin ctl_d = ALU_SR;  ai_d = req_a; end
                        OP_ADD16: begin ai_d = req_a; bi_d = req_b; end
                        default:  ;
                    endcase
                end
            end
            EXEC_LO: begin
                to_done = 1'b1;
                case (op_q)
                    OP_ADC, OP_SBC: begin
                        rsp_y_d = alu_Y;
                        flags_d = {alu_Y[7], v_bin, alu_Y == 8'h00, alu_carry_out};
`ifdef ALU_SEQUENCER_DECIMAL_EN
                        // Decimal ADC: keep the binary result and queue the nibble correction
                        if (dec_q) begin
                            to_done  = 1'b0;
                            rsp_y_d  = rsp_y_q;
                            flags_d  = flags_q;
                            v_bin_d  = v_bin;
                            hi_adj_d = hi_adj;
                            ctl_d    = ALU_ADD;
                            ai_d     = alu_Y;
                            bi_d     = {hi_adj ? 4'h6 : 4'h0, lo_adj ? 4'h6 : 4'h0};
                            cin_d    = 1'b0;
                            state_d  = BCD_FIX;
                        end
`endif
                    end
                    OP_AND, OP_ORA, OP_EOR: begin
                        rsp_y_d    = alu_Y;
                        flags_d[3] = alu_Y[7];
                        flags_d[1] = alu_Y == 8'h00;
                    end
                    OP_LSR: begin
                        rsp_y_d = alu_Y;
                        flags_d = {1'b0, flags_q[2], alu_Y == 8'h00, a_q[0]};
                    end
                    OP_ADD16: begin
                        to_done    = 1'b0;
                        y_lo_d     = alu_Y;
                        lo_carry_d = alu_carry_out;
                        ctl_d      = ALU_ADD;
                        ai_d       = hi_q;
                        bi_d       = '0;
                        cin_d      = alu_carry_out;
                        state_d    = EXEC_HI;
                    end
                    default: rsp_y_d = a_q;
                endcase
                if (to_done) begin
                    rsp_y_hi_d = '0;
                    rsp_pc_d   = 1'b0;
                end
            end
            EXEC_HI: begin
                to_done    = 1'b1;
                rsp_y_d    = y_lo_q;
                rsp_y_hi_d = alu_Y;
                rsp_pc_d   = lo_carry_q;
            end
`ifdef ALU_SEQUENCER_DECIMAL_EN
            BCD_FIX: begin
                to_done    = 1'b1;
                rsp_y_d    = alu_Y;
                rsp_y_hi_d = '0;
                rsp_pc_d   = 1'b0;
                flags_d    = {alu_Y[7], v_bin_q, alu_Y == 8'h00, hi_adj_q};
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (to_done) begin
            state_d     = DONE;
            rsp_valid_d = 1'b1;
            ctl_d       = ALU_ADD;
            ai_d        = '0;
            bi_d        = '0;
            cin_d       = 1'b0;
        end

        // Direct flag load overrides any same-edge op update
        if (flag_wr_en) begin
            flags_d = flag_wr_data;
        end

        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            op_q        <= '0;
            a_q         <= '0;
            hi_q        <= '0;
            y_lo_q      <= '0;
            lo_carry_q  <= 1'b0;
            ctl_q       <= ALU_ADD;
            ai_q        <= '0;
            bi_q        <= '0;
            cin_q       <= 1'b0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_y_q     <= '0;
            rsp_y_hi_q  <= '0;
            rsp_pc_q    <= 1'b0;
            flags_q     <= '0;
`ifdef ALU_SEQUENCER_DECIMAL_EN
            dec_q       <= 1'b0;
            v_bin_q     <= 1'b0;
            hi_adj_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            hi_q        <= hi_d;
            y_lo_q      <= y_lo_d;
            lo_carry_q  <= lo_carry_d;
            ctl_q       <= ctl_d;
            ai_q        <= ai_d;
            bi_q        <= bi_d;
            cin_q       <= cin_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_y_q     <= rsp_y_d;
            rsp_y_hi_q  <= rsp_y_hi_d;
            rsp_pc_q    <= rsp_pc_d;
            flags_q     <= flags_d;
`ifdef ALU_SEQUENCER_DECIMAL_EN
            dec_q       <= dec_d;
            v_bin_q     <= v_bin_d;
            hi_adj_q    <= hi_adj_d;
`endif
        end
    end

    assign req_ready      = req_ready_q;
    assign alu_control    = ctl_q;
    assign alu_AI         = ai_q;
    assign alu_BI         = bi_q;
    assign alu_carry_in   = cin_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_y          = rsp_y_q;
    assign rsp_y_hi       = rsp_y_hi_q;
    assign rsp_page_cross = rsp_pc_q;
    assign {flag_n, flag_v, flag_z, flag_c} = flags_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioural 8-bit ALU attached.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       resetn;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_op;
    logic [7:0] req_a, req_b, req_hi;
    logic       dec_mode;
    logic       flag_wr_en;
    logic [3:0] flag_wr_data;
    logic [2:0] alu_control;
    logic [7:0] alu_AI, alu_BI;
    logic       alu_carry_in;
    logic [7:0] alu_Y;
    logic       alu_carry_out;
    logic       rsp_valid;
    logic [7:0] rsp_y, rsp_y_hi;
    logic       rsp_page_cross;
    logic       flag_n, flag_v, flag_z, flag_c;

    always #5 clk = ~clk;

    alu_sequencer dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_hi(req_hi), .dec_mode(dec_mode),
        .flag_wr_en(flag_wr_en), .flag_wr_data(flag_wr_data),
        .alu_control(alu_control), .alu_AI(alu_AI), .alu_BI(alu_BI),
        .alu_carry_in(alu_carry_in), .alu_Y(alu_Y), .alu_carry_out(alu_carry_out),
        .rsp_valid(rsp_valid), .rsp_y(rsp_y), .rsp_y_hi(rsp_y_hi),
        .rsp_page_cross(rsp_page_cross),
        .flag_n(flag_n), .flag_v(flag_v), .flag_z(flag_z), .flag_c(flag_c)
    );

    // Behavioural ALU
    logic [8:0] alu_sum;
    always_comb begin
        alu_sum       = 9'({1'b0, alu_AI}) + 9'({1'b0, alu_BI}) + 9'(alu_carry_in);
        alu_Y         = 8'h00;
        alu_carry_out = 1'b0;
        case (alu_control)
            3'b000: begin alu_Y = alu_sum[7:0]; alu_carry_out = alu_sum[8]; end
            3'b001: begin alu_Y = {1'b0, alu_AI[7:1]}; alu_carry_out = alu_AI[0]; end
            3'b010: alu_Y = alu_AI & alu_BI;
            3'b011: alu_Y = alu_AI | alu_BI;
            3'b100: alu_Y = alu_AI ^ alu_BI;
            default: ;
        endcase
    end

    typedef struct {
        string      name;
        logic [7:0] y;
        logic [7:0] yhi;
        logic       pc;
        logic       chk_hi;
        logic [3:0] f;
        int         lat;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t mon_e;
    int   mon_acc;
    logic prev_rsp = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: log accept edges and score every response
    always @(negedge clk) begin
        if (resetn && req_valid && req_ready) acc_q.push_back(cyc + 1);
        if (rsp_valid) begin
            chk("rsp_single_pulse", int'(prev_rsp), 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk({mon_e.name, "_y"}, int'(rsp_y), int'(mon_e.y));
                chk({mon_e.name, "_flags"}, int'({flag_n, flag_v, flag_z, flag_c}), int'(mon_e.f));
                if (mon_e.chk_hi) begin
                    chk({mon_e.name, "_y_hi"}, int'(rsp_y_hi), int'(mon_e.yhi));
                    chk({mon_e.name, "_page_cross"}, int'(rsp_page_cross), int'(mon_e.pc));
                end
                if (acc_q.size() == 0) begin
                    chk({mon_e.name, "_no_accept"}, 0, 1);
                end else begin
                    mon_acc = acc_q.pop_front();
                    chk({mon_e.name, "_latency"}, cyc - mon_acc + 1, mon_e.lat);
                end
            end
        end
        prev_rsp = rsp_valid;
    end

    task automatic push(input string name, input logic [7:0] y, input logic [7:0] yhi,
                        input logic pc, input logic chk_hi, input logic [3:0] f, input int lat);
        exp_t e;
        e.name = name; e.y = y; e.yhi = yhi; e.pc = pc; e.chk_hi = chk_hi; e.f = f; e.lat = lat;
        exp_q.push_back(e);
    endtask

    task automatic drive_req(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] hi, input logic dec);
        req_op = op; req_a = a; req_b = b; req_hi = hi; dec_mode = dec;
        req_valid = 1'b1;
    endtask

    // Returns just after the accepting edge
    task automatic wait_accept();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (req_ready) done = 1'b1;
        end
        if (!done) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) done = 1'b1;
        end
        if (!done) chk("response_timeout", int'(exp_q.size()), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] hi, input logic dec,
                          input logic [7:0] y, input logic [7:0] yhi, input logic pc,
                          input logic chk_hi, input logic [3:0] f, input int lat);
        push(name, y, yhi, pc, chk_hi, f, lat);
        drive_req(op, a, b, hi, dec);
        wait_accept();
        req_valid = 1'b0;
        wait_drain();
    endtask

    task automatic flag_load(input logic [3:0] d);
        flag_wr_en = 1'b1; flag_wr_data = d;
        @(posedge clk);
        #1;
        flag_wr_en = 1'b0;
        @(negedge clk);
        chk("flag_load", int'({flag_n, flag_v, flag_z, flag_c}), int'(d));
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"},   int'(req_ready), 0);
        chk({tag, "_rsp_valid"},   int'(rsp_valid), 0);
        chk({tag, "_alu_control"}, int'(alu_control), 0);
        chk({tag, "_alu_AI"},      int'(alu_AI), 0);
        chk({tag, "_alu_BI"},      int'(alu_BI), 0);
        chk({tag, "_alu_cin"},     int'(alu_carry_in), 0);
        chk({tag, "_rsp_y"},       int'(rsp_y), 0);
        chk({tag, "_rsp_y_hi"},    int'(rsp_y_hi), 0);
        chk({tag, "_page_cross"},  int'(rsp_page_cross), 0);
        chk({tag, "_flags"},       int'({flag_n, flag_v, flag_z, flag_c}), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy;
        resetn = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; req_hi = '0;
        dec_mode = 1'b0; flag_wr_en = 1'b0; flag_wr_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("por");
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("ready_after_por", int'(req_ready), 1);
        @(posedge clk); #1;

        run_op("adc_50_50", 3'b000, 8'h50, 8'h50, 8'h00, 1'b0, 8'hA0, 8'h00, 1'b0, 1'b0, 4'b1100, 2);

        flag_load(4'b0001);
        push("sbc_00_01", 8'hFF, 8'h00, 1'b0, 1'b0, 4'b1000, 2);
        drive_req(3'b001, 8'h00, 8'h01, 8'h00, 1'b0);
        wait_accept();
        req_valid = 1'b0;
        @(negedge clk);
        chk("sbc_drive_control", int'(alu_control), 0);
        chk("sbc_drive_AI", int'(alu_AI), 'h00);
        chk("sbc_drive_BI", int'(alu_BI), 'hFE);
        chk("sbc_drive_cin", int'(alu_carry_in), 1);
        wait_drain();

        // Same-edge direct load beats the ADC flag update
        push("adc_same_edge_wr", 8'h00, 8'h00, 1'b0, 1'b0, 4'b0000, 2);
        drive_req(3'b000, 8'h80, 8'h80, 8'h00, 1'b0);
        wait_accept();
        req_valid = 1'b0;
        flag_wr_en = 1'b1; flag_wr_data = 4'b0000;
        @(posedge clk); #1;
        flag_wr_en = 1'b0;
        wait_drain();

        run_op("lsr_01",   3'b101, 8'h01, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 4'b0011, 2);
        run_op("and_f0_0f",3'b010, 8'hF0, 8'h0F, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 4'b0011, 2);
        run_op("ora_80_01",3'b011, 8'h80, 8'h01, 8'h00, 1'b0, 8'h81, 8'h00, 1'b0, 1'b0, 4'b1001, 2);
        run_op("eor_ff_0f",3'b100, 8'hFF, 8'h0F, 8'h00, 1'b0, 8'hF0, 8'h00, 1'b0, 1'b0, 4'b1001, 2);

        // ADD16 with req_valid held high: the next request waits for IDLE
        push("add16_12ff_01", 8'h00, 8'h13, 1'b1, 1'b1, 4'b1001, 3);
        push("adc_held_7f_01", 8'h81, 8'h00, 1'b0, 1'b0, 4'b1100, 2);
        drive_req(3'b110, 8'hFF, 8'h01, 8'h12, 1'b0);
        wait_accept();
        drive_req(3'b000, 8'h7F, 8'h01, 8'h00, 1'b0);
        busy = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (req_ready) break;
            busy++;
        end
        chk("add16_busy_cycles", busy, 3);
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_drain();

        run_op("reserved_5a", 3'b111, 8'h5A, 8'h33, 8'h00, 1'b0, 8'h5A, 8'h00, 1'b0, 1'b0, 4'b1100, 2);
        run_op("add16_2010_05", 3'b110, 8'h10, 8'h05, 8'h20, 1'b0, 8'h15, 8'h20, 1'b0, 1'b1, 4'b1100, 3);

`ifdef ALU_SEQUENCER_DECIMAL_EN
        run_op("adc_dec_09_01", 3'b000, 8'h09, 8'h01, 8'h00, 1'b1, 8'h10, 8'h00, 1'b0, 1'b0, 4'b0000, 3);
        run_op("adc_dec_99_01", 3'b000, 8'h99, 8'h01, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 4'b0011, 3);
`else
        run_op("adc_dec_09_01", 3'b000, 8'h09, 8'h01, 8'h00, 1'b1, 8'h0A, 8'h00, 1'b0, 1'b0, 4'b0000, 2);
        run_op("adc_dec_99_01", 3'b000, 8'h99, 8'h01, 8'h00, 1'b1, 8'h9A, 8'h00, 1'b0, 1'b0, 4'b1000, 2);
`endif

        flag_load(4'b0001);
        run_op("sbc_dec_10_01", 3'b001, 8'h10, 8'h01, 8'h00, 1'b1, 8'h0F, 8'h00, 1'b0, 1'b0, 4'b0001, 2);

        // Reset during EXEC_HI of an ADD16 discards it
        drive_req(3'b110, 8'hF0, 8'h20, 8'h40, 1'b0);
        wait_accept();
        req_valid = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("mid_reset");
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("ready_after_mid_reset", int'(req_ready), 1);
        acc_q.delete();
        @(posedge clk); #1;

        run_op("adc_post_reset", 3'b000, 8'h01, 8'h01, 8'h00, 1'b0, 8'h02, 8'h00, 1'b0, 1'b0, 4'b0000, 2);

        repeat (4) @(posedge clk);
        chk("leftover_expected", int'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
